// File: rtl/io_timer.sv
// io_timer: memory-mapped countdown timer at byte addresses 0x7F00-0x7F0F with registered read data and IRQ.
// Optional macro TIMER_PRESCALER_EN adds CTRL[15:8] = PS, giving one count tick every PS+1 counting cycles.
module io_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:2] PrAddr,
   input  logic [31:0] PrWD,
   input  logic [3:0]  PrBE,
   input  logic        IOWrite,
   output logic [31:0] PrRD,
   output logic        IRQ
);

   typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

   state_t      state, state_next;
   logic [3:0]  ctrl, ctrl_d;
   logic [31:0] preset, preset_d;
   logic [31:0] count, count_d;
   logic [31:0] ctrl_word, rd_d;
   logic        sel, wr_ctrl, wr_preset, stop_wr, tick, auto_reload, irq_d;
   logic        addr_unused;

   // Only PrAddr[15:4] takes part in decode; the upper address bits alias.
   assign addr_unused = ^PrAddr[31:16];
   assign sel         = (PrAddr[15:4] == 12'h7F0);
   assign wr_ctrl     = sel && IOWrite && (PrAddr[3:2] == 2'd0);
   assign wr_preset   = sel && IOWrite && (PrAddr[3:2] == 2'd1);
   assign stop_wr     = wr_ctrl && PrBE[0] && !PrWD[0];
   assign auto_reload = (ctrl[2:1] == 2'b01);

`ifdef TIMER_PRESCALER_EN
   logic [7:0] ps, ps_d, ps_cnt;

   always_comb begin
      ps_d = ps;
      if (wr_ctrl && PrBE[1])
         ps_d = PrWD[15:8];
   end

   assign tick      = (ps_cnt == ps);
   assign ctrl_word = {16'd0, ps, 4'd0, ctrl};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ps     <= '0;
         ps_cnt <= '0;
      end else begin
         ps <= ps_d;
         if (state != CNT || tick)
            ps_cnt <= '0;
         else
            ps_cnt <= ps_cnt + 8'd1;
      end
   end
`else
   assign tick      = 1'b1;
   assign ctrl_word = {28'd0, ctrl};
`endif

   // NOTE: every combinational output gets a default before any branch, so no path leaves a latch behind.
   always_comb begin
      ctrl_d   = ctrl;
      preset_d = preset;
      if (wr_ctrl && PrBE[0])
         ctrl_d = PrWD[3:0];
      for (int i = 0; i < 4; i++)
         if (wr_preset && PrBE[i])
            preset_d[8*i +: 8] = PrWD[8*i +: 8];
   end

   // Counting follows the CTRL value already in the register; a write only lands next cycle.
   always_comb begin
      state_next = state;
      count_d    = count;
      case (state)
         IDLE: if (ctrl[0]) state_next = LOAD;
         LOAD: begin
            count_d    = preset;
            state_next = CNT;
         end
         CNT: begin
            if (!ctrl[0]) begin
               state_next = IDLE;
            end else if (tick) begin
               if (count <= 32'd1) begin
                  count_d    = '0;
                  state_next = INT;
               end else begin
                  count_d = count - 32'd1;
               end
            end
         end
         INT: begin
            if (!ctrl[0])
               state_next = IDLE;
            else if (auto_reload)
               state_next = LOAD;
         end
         default: state_next = IDLE;
      endcase
      // Clearing EN stops the timer at the very next edge, whatever state it is in.
      if (stop_wr)
         state_next = IDLE;
   end

   assign irq_d = ctrl_d[3] && (state_next == INT);

   always_comb begin
      rd_d = '0;
      if (sel) begin
         case (PrAddr[3:2])
            2'd0:    rd_d = ctrl_word;
            2'd1:    rd_d = preset;
            2'd2:    rd_d = count;
            default: rd_d = '0;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         ctrl   <= '0;
         preset <= '0;
         count  <= '0;
         PrRD   <= '0;
         IRQ    <= 1'b0;
      end else begin
         state  <= state_next;
         ctrl   <= ctrl_d;
         preset <= preset_d;
         count  <= count_d;
         PrRD   <= rd_d;
         IRQ    <= irq_d;
      end
   end

endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: scoreboard bench for io_timer; a spec-level model predicts PrRD/IRQ for each issued bus cycle.
// Directed scenarios cover one-shot, auto-reload, IM gating, byte lanes and async reset; random traffic follows.
module tb_io_timer;

   localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
   localparam logic [31:0] A_PRESET = 32'h0000_7F04;
   localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
   localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;

   localparam int PH_IDLE = 0;
   localparam int PH_LOAD = 1;
   localparam int PH_CNT  = 2;
   localparam int PH_INT  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [29:0] pr_addr = '0;
   logic [31:0] pr_wd = '0;
   logic [3:0]  pr_be = '0;
   logic        io_write = 1'b0;
   logic [31:0] pr_rd;
   logic        irq;

   typedef struct {
      logic [31:0] rd;
      logic        irq;
   } exp_t;

   exp_t sb[$];
   int   hi[$];
   int   first_hi;
   int   n_cmp = 0;
   int   n_fail = 0;

   // Reference state, kept at the level of the register map and timer phases.
   logic        m_en, m_im;
   logic [1:0]  m_mode;
   logic [31:0] m_preset, m_count;
   int          m_phase;

   io_timer dut (
      .clk     (clk),
      .rst     (rst),
      .PrAddr  (pr_addr),
      .PrWD    (pr_wd),
      .PrBE    (pr_be),
      .IOWrite (io_write),
      .PrRD    (pr_rd),
      .IRQ     (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic [31:0] baddr, input logic [31:0] wd,
                             input logic [3:0] be, input logic wr, output exp_t e);
      logic        s;
      logic [1:0]  off;
      int          nxt;
      logic [31:0] ncount;
      e.rd  = '0;
      e.irq = 1'b0;
      if (r) begin
         m_en = 1'b0; m_im = 1'b0; m_mode = 2'b00;
         m_preset = '0; m_count = '0; m_phase = PH_IDLE;
         return;
      end
      s   = (baddr[15:4] == 12'h7F0);
      off = baddr[3:2];
      if (s) begin
         if (off == 2'd0) e.rd = {28'd0, m_im, m_mode, m_en};
         else if (off == 2'd1) e.rd = m_preset;
         else if (off == 2'd2) e.rd = m_count;
      end
      nxt    = m_phase;
      ncount = m_count;
      if (m_phase == PH_IDLE) begin
         if (m_en) nxt = PH_LOAD;
      end else if (m_phase == PH_LOAD) begin
         ncount = m_preset;
         nxt    = PH_CNT;
      end else if (m_phase == PH_CNT) begin
         if (!m_en) nxt = PH_IDLE;
         else if (m_count <= 1) begin ncount = 0; nxt = PH_INT; end
         else ncount = m_count - 1;
      end else begin
         if (!m_en) nxt = PH_IDLE;
         else if (m_mode == 2'b01) nxt = PH_LOAD;
      end
      if (s && wr) begin
         if (off == 2'd0 && be[0]) begin
            m_en = wd[0]; m_mode = wd[2:1]; m_im = wd[3];
            if (!wd[0]) nxt = PH_IDLE;
         end
         if (off == 2'd1)
            for (int i = 0; i < 4; i++)
               if (be[i]) m_preset[8*i +: 8] = wd[8*i +: 8];
      end
      m_phase = nxt;
      m_count = ncount;
      e.irq   = m_im && (nxt == PH_INT);
   endtask

   // Drive one bus cycle at the falling edge and queue what the next rising edge must produce.
   task automatic bus(input logic r, input logic [31:0] baddr, input logic [31:0] wd,
                      input logic [3:0] be, input logic wr);
      exp_t e;
      @(negedge clk);
      rst      = r;
      pr_addr  = baddr[31:2];
      pr_wd    = wd;
      pr_be    = be;
      io_write = wr;
      model_step(r, baddr, wd, be, wr, e);
      sb.push_back(e);
   endtask

   task automatic watch(input int n);
      hi.delete();
      first_hi = -1;
      for (int k = 1; k <= n; k++) begin
         bus(1'b0, A_COUNT, 32'd0, 4'h0, 1'b0);
         @(posedge clk);
         #3;
         if (irq) begin
            hi.push_back(k);
            if (first_hi < 0) first_hi = k;
         end
      end
   endtask

   task automatic wr_reg(input logic [31:0] baddr, input logic [31:0] wd);
      bus(1'b0, baddr, wd, 4'hF, 1'b1);
   endtask

   // Monitor: one expectation is retired per rising edge, sampled after outputs settle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sb_prrd", pr_rd, e.rd);
            check("sb_irq", 32'(irq), 32'(e.irq));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached without finishing");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] tmp, baddr, wd;
      logic [3:0]  be;
      logic        wr, r;
      int          sel_r;

      #1;
      check("reset_prrd", pr_rd, 32'd0);
      check("reset_irq", 32'(irq), 32'd0);
      bus(1'b1, A_CTRL, 32'd0, 4'h0, 1'b0);
      bus(1'b1, A_CTRL, 32'd0, 4'h0, 1'b0);
      bus(1'b0, A_CTRL, 32'd0, 4'h0, 1'b0);

      // Byte-lane write to PRESET and ignored writes to COUNT / reserved.
      wr_reg(A_PRESET, 32'h1122_3344);
      bus(1'b0, A_PRESET, 32'h0000_AB00, 4'b0010, 1'b1);
      bus(1'b0, A_PRESET, 32'd0, 4'h0, 1'b0);
      @(posedge clk); #3;
      check("preset_bytelane", pr_rd, 32'h1122_AB44);
      wr_reg(A_COUNT, 32'hFFFF_FFFF);
      wr_reg(A_RSVD, 32'hFFFF_FFFF);
      bus(1'b0, A_COUNT, 32'd0, 4'h0, 1'b0);
      @(posedge clk); #3;
      check("count_write_ignored", pr_rd, 32'd0);
      bus(1'b0, A_RSVD, 32'd0, 4'h0, 1'b0);
      bus(1'b0, 32'h0000_1F00, 32'd0, 4'h0, 1'b0);

      // One-shot: PRESET=5, CTRL=0x9.
      wr_reg(A_PRESET, 32'd5);
      wr_reg(A_CTRL, 32'h9);
      watch(10);
      check("oneshot_rise", 32'(first_hi), 32'd7);
      check("oneshot_held", 32'(hi.size()), 32'd4);
      wr_reg(A_CTRL, 32'h0);
      @(posedge clk); #3;
      check("oneshot_clear", 32'(irq), 32'd0);

      // Auto-reload: PRESET=3, CTRL=0xB.
      wr_reg(A_PRESET, 32'd3);
      wr_reg(A_CTRL, 32'hB);
      watch(20);
      check("reload_first", 32'(first_hi), 32'd5);
      check("reload_pulses", 32'(hi.size()), 32'd4);
      for (int i = 1; i < hi.size(); i++)
         check("reload_period", 32'(hi[i] - hi[i-1]), 32'd5);
      wr_reg(A_CTRL, 32'h0);

      // IM gating: INT reached silently, then enabling IM raises IRQ next cycle.
      wr_reg(A_PRESET, 32'd2);
      wr_reg(A_CTRL, 32'h1);
      watch(8);
      check("masked_no_irq", 32'(hi.size()), 32'd0);
      wr_reg(A_CTRL, 32'h9);
      @(posedge clk); #3;
      check("unmask_irq", 32'(irq), 32'd1);
      wr_reg(A_CTRL, 32'h0);

      // PRESET=0 goes LOAD -> CNT -> INT.
      wr_reg(A_PRESET, 32'd0);
      wr_reg(A_CTRL, 32'h9);
      watch(5);
      check("preset0_rise", 32'(first_hi), 32'd3);
      wr_reg(A_CTRL, 32'h0);

      // Asynchronous reset mid-count at COUNT=3.
      wr_reg(A_PRESET, 32'd6);
      wr_reg(A_CTRL, 32'h9);
      watch(5);
      check("pre_reset_rd", pr_rd, 32'd4);
      bus(1'b1, A_COUNT, 32'd0, 4'h0, 1'b0);
      #1;
      check("async_rst_prrd", pr_rd, 32'd0);
      check("async_rst_irq", 32'(irq), 32'd0);
      bus(1'b0, A_COUNT, 32'd0, 4'h0, 1'b0);
      watch(10);
      check("no_irq_after_rst", 32'(hi.size()), 32'd0);

      // Randomised traffic.
      for (int n = 0; n < 1500; n++) begin
         sel_r = $urandom_range(0, 99);
         tmp   = $urandom;
         r     = 1'b0;
         wr    = 1'b0;
         wd    = '0;
         be    = 4'h0;
         baddr = {tmp[31:16], 12'h7F0, tmp[3:2], 2'b00};
         if (sel_r < 30) begin
            wd = $urandom;
         end else if (sel_r < 40) begin
            baddr = $urandom;
            baddr[1:0] = 2'b00;
            if (baddr[15:4] == 12'h7F0) baddr[4] = ~baddr[4];
            wd = $urandom;
            be = 4'(($urandom));
            wr = 1'($urandom);
         end else if (sel_r < 55) begin
            baddr[3:2] = 2'd0;
            wd    = $urandom;
            wd[0] = ($urandom_range(0, 9) != 0);
            be    = 4'(($urandom));
            wr    = 1'b1;
         end else if (sel_r < 65) begin
            baddr[3:2] = 2'd1;
            wd = 32'($urandom_range(0, 6));
            be = 4'(($urandom));
            wr = 1'b1;
         end else if (sel_r < 70) begin
            baddr[3:2] = 2'(($urandom_range(2, 3)));
            wd = $urandom;
            be = 4'hF;
            wr = 1'b1;
         end else if (sel_r < 71) begin
            r = 1'b1;
         end else begin
            baddr[3:2] = 2'd2;
         end
         bus(r, baddr, wd, be, wr);
      end
      bus(1'b0, A_CTRL, 32'd0, 4'h0, 1'b0);

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      #3;
      if (sb.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
